// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_t : receiver FSM state encoding.
//   calc_div()      : clock cycles per bit, rounded to nearest. The transmitter
//                     uses this function too, so both sides agree on bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer, first-word fall-through.
// Ports:
//   clk_sys, reset_n : clock, synchronous active-low reset
//   push_i           : write push_data_i; ignored when full unless pop_i is
//                      accepted in the same cycle
//   push_data_i[7:0] : byte to store
//   pop_i            : drop the head byte; ignored when empty
//   full_o, empty_o  : occupancy flags
//   count_o          : bytes held, 0..DEPTH
//   head_o[7:0]      : head byte, 8'h00 when empty
// DEPTH may be 1 (single holding register) or a power of two.
module uart_rx_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [7:0]       push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [7:0]       head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a push into a full
    // buffer is accepted when it coincides with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_o is masked while empty.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with receive buffer and sticky error flags.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; without
// it the buffer is a single holding register and FIFO_DEPTH is only
// range-checked.
// Ports:
//   clk_sys, reset_n  : clock, synchronous active-low reset
//   uart_rx_i         : asynchronous serial line, idle high
//   rd_strobe_i       : pop the head byte (ignored when empty)
//   clr_err_i         : clear sticky flags; a same-cycle set event wins
//   data_o[7:0]       : head byte, 8'h00 when empty
//   valid_o           : buffer non-empty
//   count_o           : bytes buffered
//   overrun_o         : sticky, byte dropped on a full buffer
//   framing_err_o     : sticky, stop bit sampled low
module uart_rx
    import uart_pkg::*;
#(
    parameter  int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter  int unsigned BAUDRATE    = 115_200,
    parameter  int unsigned FIFO_DEPTH  = 16,
`ifdef UART_RX_FIFO_EN
    localparam int unsigned BUF_DEPTH   = FIFO_DEPTH,
`else
    localparam int unsigned BUF_DEPTH   = 1,
`endif
    localparam int unsigned CNT_W       = $clog2(BUF_DEPTH) + 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             uart_rx_i,
    input  logic             rd_strobe_i,
    input  logic             clr_err_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overrun_o,
    output logic             framing_err_o
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUDRATE);
    localparam int unsigned TMR_W = $clog2(DIV);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: CLK_FREQ_HZ/BAUDRATE must round to at least 4");
    end

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_depth_check
        $error("uart_rx: FIFO_DEPTH must be a power of two in 2..256");
    end

    uart_rx_state_t   state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic             rx_prev_q, rx_prev_d;
    logic [1:0]       settle_q, settle_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push_q, push_d;
    logic             overrun_q, overrun_d;
    logic             framing_q, framing_d;
    logic             frame_err_evt, overrun_evt;
    logic             settled, start_edge;
    logic             buf_full, buf_empty;

    // The synchronizer is preset high, so for two cycles after reset rx_s_q
    // does not reflect the line. Edge detection stays disarmed until real
    // samples arrive; a line held low through reset is then never a start.
    assign settled    = (settle_q == 2'd2);
    assign start_edge = rx_prev_q & ~rx_s_q;

    always_comb begin
        settle_d      = settled ? settle_q : settle_q + 2'd1;
        rx_prev_d     = settled ? rx_s_q : 1'b0;
        state_d       = state_q;
        tmr_d         = tmr_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        push_d        = 1'b0;
        frame_err_evt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    tmr_d   = TMR_W'(DIV / 2 - 1);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tmr_q == '0) begin
                    if (!rx_s_q) begin
                        tmr_d     = TMR_W'(DIV - 1);
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StData: begin
                if (tmr_q == '0) begin
                    shreg_d[bit_idx_q] = rx_s_q;
                    tmr_d              = TMR_W'(DIV - 1);
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StStop: begin
                if (tmr_q == '0) begin
                    if (rx_s_q) begin
                        push_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_evt = 1'b1;
                        state_d       = StBreak;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mirrors the buffer's accept rule: a drop happens only when full and
    // no pop is accepted in the same cycle.
    assign overrun_evt = push_q & buf_full & ~rd_strobe_i;

    always_comb begin
        overrun_d = (overrun_q & ~clr_err_i) | overrun_evt;
        framing_d = (framing_q & ~clr_err_i) | frame_err_evt;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b0;
            settle_q  <= 2'd0;
            state_q   <= StIdle;
            tmr_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            push_q    <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_prev_d;
            settle_q  <= settle_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            push_q    <= push_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .push_i      (push_q),
        .push_data_i (shreg_q),
        .pop_i       (rd_strobe_i),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (count_o),
        .head_o      (data_o)
    );

    assign valid_o       = ~buf_empty;
    assign overrun_o     = overrun_q;
    assign framing_err_o = framing_q;

endmodule
